// File: rtl/note_draw_scheduler.sv
// Note-row redraw scheduler: on each accepted frame tick, paints ten 4x4
// squares, one pixel per cycle, coloured from the latched note sequences.
module note_draw_scheduler #(
    parameter logic [7:0] X_BASE = 8'd0,
    parameter logic [7:0] X_STEP = 8'd16,
    parameter logic [6:0] Y_ROW  = 7'd58
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] red_sequence,
    input  logic [9:0] yellow_sequence,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DRAW = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned LAST_SLOT  = 9;
    localparam int unsigned LAST_PIXEL = 15;

    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_BLANK  = 3'b000;

    logic [1:0] state, state_n;
    logic [3:0] slot, slot_n;
    logic [3:0] pixel, pixel_n;
    logic [9:0] red_q, red_n;
    logic [9:0] yel_q, yel_n;

    logic [7:0] x_n;
    logic [6:0] y_n;
    logic [2:0] colour_n;
    logic       plot_n, busy_n, done_n, overrun_n;

    // State, counters, latched sequences and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            slot    <= 4'd0;
            pixel   <= 4'd0;
            red_q   <= 10'd0;
            yel_q   <= 10'd0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            slot    <= slot_n;
            pixel   <= pixel_n;
            red_q   <= red_n;
            yel_q   <= yel_n;
            x       <= x_n;
            y       <= y_n;
            colour  <= colour_n;
            plot    <= plot_n;
            busy    <= busy_n;
            done    <= done_n;
            overrun <= overrun_n;
        end
    end

    // Next-state, counter advance and next pixel; outputs are computed from
    // the next counter values so the registered pixel lines up with state
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        pixel_n   = pixel;
        red_n     = red_q;
        yel_n     = yel_q;
        x_n       = x;
        y_n       = y;
        colour_n  = colour;
        plot_n    = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        overrun_n = 1'b0;

        case (state)
            IDLE: begin
                if (tick) begin
                    red_n   = red_sequence;
                    yel_n   = yellow_sequence;
                    slot_n  = 4'd0;
                    pixel_n = 4'd0;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                overrun_n = tick;
                if (pixel == 4'(LAST_PIXEL)) begin
                    pixel_n = 4'd0;
                    if (slot == 4'(LAST_SLOT)) begin
                        state_n = DONE;
                    end else begin
                        slot_n = slot + 4'd1;
                    end
                end else begin
                    pixel_n = pixel + 4'd1;
                end
            end
            DONE: begin
                overrun_n = tick;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        plot_n = (state_n == DRAW);
        busy_n = (state_n == DRAW);
        done_n = (state_n == DONE);

        if (plot_n) begin
            x_n = X_BASE + 8'(slot_n) * X_STEP + 8'(pixel_n[1:0]);
            y_n = Y_ROW + 7'(pixel_n[3:2]);
            if (red_n[slot_n]) begin
                colour_n = COL_RED;
            end else if (yel_n[slot_n]) begin
                colour_n = COL_YELLOW;
            end else begin
                colour_n = COL_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_note_draw_scheduler.sv
// Directed bench for note_draw_scheduler: table of redraw vectors plus
// hand-written sequences for mid-draw changes, held ticks and reset abort.
module tb_note_draw_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [9:0] red_sequence;
    logic [9:0] yellow_sequence;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, overrun;

    int n_vec = 0;
    int n_err = 0;

    note_draw_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .red_sequence    (red_sequence),
        .yellow_sequence (yellow_sequence),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]       red;
        logic [9:0]       yel;
        logic [9:0][2:0]  exp_col;   // {slot9 .. slot0}
        logic [9:0]       red2;      // sequences applied mid-draw
        logic [9:0]       yel2;
        int               mid;       // cycle of mid-draw change + tick, -1 none
        int               tick_len;  // cycles tick is held from acceptance
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete redraw starting from IDLE and checks every cycle
    task automatic run_redraw(input vec_t v);
        int slot_i, pix_i;
        logic [7:0] ex;
        logic [6:0] ey;
        red_sequence    = v.red;
        yellow_sequence = v.yel;
        tick            = 1'b1;
        step();
        for (int i = 0; i < 160; i++) begin
            slot_i = i / 16;
            pix_i  = i % 16;
            ex = 8'(slot_i * 16 + (pix_i % 4));
            ey = 7'(58 + pix_i / 4);
            chk("plot", 32'(plot), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_in_draw", 32'(done), 32'd0);
            chk("x", 32'(x), 32'(ex));
            chk("y", 32'(y), 32'(ey));
            chk("colour", 32'(colour), 32'(v.exp_col[slot_i]));
            chk("overrun", 32'(overrun),
                32'(((i >= 1) && (i <= v.tick_len - 1)) || (v.mid >= 0 && i == v.mid + 1)));
            tick = (i < v.tick_len - 1) || (i == v.mid);
            if (i == v.mid) begin
                red_sequence    = v.red2;
                yellow_sequence = v.yel2;
            end
            step();
        end
        tick = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("plot_done", 32'(plot), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
        chk("x_hold", 32'(x), 32'd147);
        chk("y_hold", 32'(y), 32'd61);
        chk("overrun_done", 32'(overrun), 32'(v.tick_len > 160));
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("plot_idle", 32'(plot), 32'd0);
    endtask

    initial begin
        vecs[0] = '{10'b0110101010, 10'b0000000000,
                    {3'b000,3'b100,3'b100,3'b000,3'b100,3'b000,3'b100,3'b000,3'b100,3'b000},
                    10'd0, 10'd0, -1, 1};
        vecs[1] = '{10'b0000000001, 10'b0000000011,
                    {3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b110,3'b100},
                    10'd0, 10'd0, -1, 1};
        vecs[2] = '{10'b1000000001, 10'b1100000010,
                    {3'b100,3'b110,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b110,3'b100},
                    10'd0, 10'd0, -1, 1};
        vecs[3] = '{10'b0000000000, 10'b1111111111,
                    {3'b110,3'b110,3'b110,3'b110,3'b110,3'b110,3'b110,3'b110,3'b110,3'b110},
                    10'd0, 10'd0, -1, 1};
        // mid-draw sequence change plus a dropped tick at cycle 50
        vecs[4] = '{10'b0110101010, 10'b0000000000,
                    {3'b000,3'b100,3'b100,3'b000,3'b100,3'b000,3'b100,3'b000,3'b100,3'b000},
                    10'b1001010101, 10'b1111111111, 50, 1};
        // tick held three cycles from IDLE
        vecs[5] = '{10'b0000000000, 10'b0000000000,
                    {3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000,3'b000},
                    10'd0, 10'd0, -1, 3};

        reset = 1'b1;
        tick = 1'b0;
        red_sequence = 10'h3ff;
        yellow_sequence = 10'h3ff;
        #1;
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_plot", 32'(plot), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // back-to-back: each call ticks in the cycle right after DONE
        for (int k = 0; k < 6; k++) begin
            run_redraw(vecs[k]);
        end

        // reset abort at plot cycle 80
        red_sequence    = 10'h3ff;
        yellow_sequence = 10'h000;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 80; i++) step();
        chk("pre_rst_plot", 32'(plot), 32'd1);
        chk("pre_rst_x", 32'(x), 32'd80);
        chk("pre_rst_colour", 32'(colour), 32'd4);
        reset = 1'b1;
        #1;
        chk("abort_plot", 32'(plot), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_colour", 32'(colour), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        run_redraw(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_draw_scheduler.md
NOTE_DRAW_SCHEDULER -- requirements
Module: note_draw_scheduler

Interface
REQ-001 Parameter X_BASE, default 8'd0: x pixel of slot 0's top-left corner.
REQ-002 Parameter X_STEP, default 8'd16: x spacing between adjacent slots.
REQ-003 Parameter Y_ROW, default 7'd58: y pixel of the top row of every square.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  frame strobe; requests one redraw of the note row.
REQ-007 red_sequence  input  10  bit i set = slot i holds a red note.
REQ-008 yellow_sequence  input  10  bit i set = slot i holds a yellow note.
REQ-009 x  output  8  pixel x coordinate to the VGA adapter.
REQ-010 y  output  7  pixel y coordinate to the VGA adapter.
REQ-011 colour  output  3  pixel colour {R,G,B}.
REQ-012 plot  output  1  write enable; x, y and colour are valid while it is high.
REQ-013 busy  output  1  high while a redraw is in progress.
REQ-014 done  output  1  one-cycle pulse when a redraw completes.
REQ-015 overrun  output  1  one-cycle pulse when a tick is dropped.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-017 IDLE: tick=1 at a rising edge SHALL latch both sequences into internal registers, clear slot and pixel counters, and move to DRAW.
REQ-018 Sequence inputs SHALL be sampled only at tick acceptance; later changes SHALL not affect the redraw in progress.
REQ-019 DRAW: one pixel SHALL be emitted per cycle; slot counter 0..9, pixel counter 0..15.
REQ-020 Pixel offsets: xoff = pixel[1:0] (fastest), yoff = pixel[3:2].
REQ-021 x SHALL equal X_BASE + slot*X_STEP + xoff, truncated to 8 bits; y SHALL equal Y_ROW + yoff, truncated to 7 bits.
REQ-022 colour SHALL be 3'b100 if the latched red bit[slot]=1, else 3'b110 if the latched yellow bit[slot]=1, else 3'b000 (red wins when both are set).
REQ-023 x, y, colour and plot SHALL be registered outputs; plot=1 exactly in cycles whose outputs form a valid pixel.
REQ-024 Pixel 15 SHALL advance slot and reset pixel to 0; at slot 9 pixel 15 the FSM SHALL move to DONE.
REQ-025 A redraw SHALL produce exactly 160 consecutive plot=1 cycles, starting the cycle after tick acceptance.
REQ-026 DONE SHALL last one cycle, with done=1, plot=0 and busy=0, then return to IDLE.
REQ-027 busy SHALL be 1 in every DRAW cycle and 0 otherwise.
REQ-028 Outside DRAW, plot SHALL be 0 and x, y and colour SHALL hold their last values.
REQ-029 A tick in DRAW or DONE SHALL be ignored and SHALL pulse overrun for one cycle on the next cycle; no tick is queued.
REQ-030 A tick held high for N cycles in IDLE SHALL start one redraw; the remaining high cycles fall in DRAW/DONE and are overruns.
REQ-031 The cycle after DONE is IDLE, so a tick present then SHALL be accepted.

Reset
REQ-032 reset=1 SHALL immediately force: state IDLE, slot 0, pixel 0, latched sequences 0, x 0, y 0, colour 0, plot 0, busy 0, done 0, overrun 0.
REQ-033 Reset asserted mid-redraw SHALL abort it with no done pulse; the first tick after reset release SHALL start a fresh redraw from slot 0.

Verification
REQ-034 red=10'b0110101010, yellow=0, one-cycle tick -> 160 plot cycles; slots 1,3,5,7,8 colour 100, others 000; first pixel (0,58); last pixel (147,61); done one cycle after the last plot.
REQ-035 red=10'b0000000001, yellow=10'b0000000011 -> slot 0 colour 100, slot 1 colour 110, slots 2-9 colour 000.
REQ-036 Sequences changed at cycle 50 of a redraw -> remaining pixels use the latched values; a tick at cycle 50 -> overrun pulses once; busy stays 1.
REQ-037 reset pulsed at plot cycle 80 -> plot 0, busy 0, all outputs 0 at once; no done pulse; a tick after release restarts at slot 0, pixel (0,58).
REQ-038 tick high for 3 cycles from IDLE -> exactly one redraw of 160 plot cycles; overrun pulses twice.
REQ-039 tick in the cycle right after done -> accepted; the next redraw starts with no gap beyond the DONE cycle.
